// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice per clock, LSB first,
// with the carry held in a flop between cycles. Low-area alternative to the parallel adders.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module bit_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, next_state;
    logic [WIDTH-1:0]   a_sh, b_sh;
    logic [WIDTH-2:0]   res_sh;
    logic [WIDTH-1:0]   res_full;
    logic               carry;
    logic [CW-1:0]      cnt;
    logic               last_bit;
    logic               fa_s, fa_co;

    full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    // Result bits computed so far plus this cycle's sum bit entering at the MSB.
    assign res_full = {fa_s, res_sh};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand/result datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    res_sh <= res_full[WIDTH-1:1];
                    carry  <= fa_co;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CW'(1);
                    // carry still holds the carry into the MSB on the final slice.
                    if (last_bit) begin
                        sum      <= res_full;
                        cout     <= fa_co;
                        overflow <= carry ^ fa_co;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder at WIDTH=8 and WIDTH=16 against an arithmetic model.

module tb_bit_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, cin16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    bit_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [33:0] q8[$];
    logic [33:0] q16[$];
    int left8 = 0, left16 = 0, acc8 = 0, acc16 = 0;
    int cyc = 0, dones8 = 0, dones16 = 0;
    int last8 = -1, last16 = -1;
    bit thr = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Returns {overflow, cout, sum zero-extended to 32 bits}.
    function automatic logic [33:0] model(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic c);
        logic [32:0] t;
        logic [31:0] m, s;
        logic co, ov;
        t  = 33'(x) + 33'(y) + 33'(c);
        m  = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        s  = t[31:0] & m;
        co = t[w];
        ov = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
        return {ov, co, s};
    endfunction

    // One clock: the model sees the pre-edge inputs, then inputs may change 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            q8.delete(); q16.delete();
            left8 = 0; left16 = 0;
        end else begin
            if (left8 == 0 && start8) begin
                q8.push_back(model(8, 32'(a8), 32'(b8), cin8));
                left8 = 9; acc8++;
            end else if (left8 > 0) left8--;
            if (left16 == 0 && start16) begin
                q16.push_back(model(16, 32'(a16), 32'(b16), cin16));
                left16 = 17; acc16++;
            end else if (left16 > 0) left16--;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (done8) begin
            dones8++;
            if (q8.size() == 0) chk("done8_unexpected", 64'd1, 64'd0);
            else begin
                logic [33:0] e;
                e = q8.pop_front();
                chk("result8", {30'b0, ovf8, cout8, 24'b0, sum8}, {30'b0, e});
            end
            if (thr) begin
                if (last8 >= 0) chk("interval8", 64'(cyc - last8), 64'd10);
                last8 = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (done16) begin
            dones16++;
            if (q16.size() == 0) chk("done16_unexpected", 64'd1, 64'd0);
            else begin
                logic [33:0] e;
                e = q16.pop_front();
                chk("result16", {30'b0, ovf16, cout16, 16'b0, sum16}, {30'b0, e});
            end
            if (thr) begin
                if (last16 >= 0) chk("interval16", 64'(cyc - last16), 64'd18);
                last16 = cyc;
            end
        end
    end

    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c);
        a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int d0;
        int budget;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        tick(); tick();
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_sum", 64'(sum8), 64'd0);
        chk("rst_cout", 64'(cout8), 64'd0);
        chk("rst_ovf", 64'(ovf8), 64'd0);
        rst = 1'b0;
        tick();

        // Latency: start accepted at edge k, done visible after edge k+8.
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int j = 0; j <= 9; j++) begin
            if (j > 0) tick();
            a8 = 8'($urandom);
            chk("lat_busy", 64'(busy8), 64'(j <= 8));
            chk("lat_done", 64'(done8), 64'(j == 8));
        end
        chk("lat_sum", 64'(sum8), 64'h00);
        chk("lat_cout", 64'(cout8), 64'd1);

        run8(8'h7F, 8'h01, 1'b0);
        chk("ovf_pos_sum", 64'(sum8), 64'h80);
        chk("ovf_pos_flag", 64'(ovf8), 64'd1);
        run8(8'h80, 8'h80, 1'b0);
        chk("ovf_neg_cout", 64'(cout8), 64'd1);
        chk("ovf_neg_flag", 64'(ovf8), 64'd1);

        run8(8'h00, 8'h00, 1'b1);
        for (int j = 0; j < 20; j++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            tick();
            chk("hold_sum", 64'(sum8), 64'h01);
            chk("hold_cout", 64'(cout8), 64'd0);
        end

        // Start and operand changes while busy must be ignored.
        d0 = dones8;
        a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int j = 0; j < 6; j++) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            tick();
        end
        start8 = 1'b1; a8 = 8'($urandom);
        tick();
        start8 = 1'b0;
        repeat (14) tick();
        chk("busy_one_done", 64'(dones8 - d0), 64'd1);
        chk("busy_sum", 64'(sum8), 64'h97);

        // Reset during the 4th RUN cycle abandons the operation.
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy8), 64'd0);
        chk("mid_rst_done", 64'(done8), 64'd0);
        chk("mid_rst_sum", 64'(sum8), 64'd0);
        chk("mid_rst_cout", 64'(cout8), 64'd0);
        chk("mid_rst_ovf", 64'(ovf8), 64'd0);
        d0 = dones8;
        repeat (12) tick();
        chk("mid_rst_no_done", 64'(dones8 - d0), 64'd0);
        run8(8'h12, 8'h34, 1'b0);
        chk("post_rst_sum", 64'(sum8), 64'h46);

        // Throughput with start held high, random operands every cycle.
        thr = 1'b1; acc8 = 0; acc16 = 0; last8 = -1; last16 = -1;
        d0 = dones8;
        begin
            int d16;
            d16 = dones16;
            budget = 0;
            while ((acc8 < 1000 || acc16 < 1000) && budget < 30000) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
                start8 = (acc8 < 1000);
                start16 = (acc16 < 1000);
                tick();
                budget++;
            end
            start8 = 1'b0; start16 = 1'b0;
            budget = 0;
            while ((q8.size() > 0 || q16.size() > 0) && budget < 40) begin
                tick();
                budget++;
            end
            tick();
            thr = 1'b0;
            chk("drain8", 64'(q8.size()), 64'd0);
            chk("drain16", 64'(q16.size()), 64'd0);
            chk("ops8", 64'(dones8 - d0), 64'd1000);
            chk("ops16", 64'(dones16 - d16), 64'd1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Sequential, area-minimal WIDTH-bit adder.
- Feeds one operand bit pair plus the registered carry into a single full_adder instance per clock, LSB first.
- Collects the Sum bit and registers Cout as the next cycle's carry-in.
- Sits beside the parallel adders as the low-area alternative. Shares their operand/result conventions: unsigned sum, carry-out, signed overflow.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; latched on accepted start
- b  input  WIDTH  operand B; latched on accepted start
- cin  input  1  initial carry-in; latched on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  result; registered, held until next completion
- cout  output  1  carry out of bit WIDTH-1
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (any state, including mid-operation):
  - state=IDLE.
  - sum=0, cout=0, overflow=0, busy=0, done=0.
  - Operand shift registers, carry flop and bit counter cleared.
  - An operation in progress is abandoned and produces no done.
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. At an edge with start=1: latch a, b, cin into shift registers and carry flop; counter=0; go to RUN.
  - RUN: busy=1. Each edge:
    - full_adder inputs = (a_sh[0], b_sh[0], carry).
    - Shift Sum in at the MSB of the result shift register.
    - carry<=Cout.
    - Shift a_sh and b_sh right by 1.
    - counter++.
    - Record the carry into bit WIDTH-1 when counter==WIDTH-1.
    - On the edge where counter==WIDTH-1: copy the completed result into sum, set cout from that bit's Cout, set overflow, go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle. Next edge unconditionally goes to IDLE.
- Latency: start accepted at edge k. sum, cout and overflow are valid and done=1 in the cycle following edge k+WIDTH. Busy spans WIDTH+1 cycles. A new start can be accepted at edge k+WIDTH+2 at the earliest.
- start while busy (RUN or DONE) is ignored and not queued. A start held high continuously gives back-to-back operations, one per WIDTH+2 cycles.
- Changes on a, b, cin after acceptance have no effect on the current operation.
- sum, cout and overflow change only at a completion edge or at reset. Partial results are never visible.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). overflow = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
- Counter width: clog2(WIDTH) bits. No wrap issue, since RUN exits at WIDTH-1.

Test Plan:
- Completion and latency (WIDTH=8): a=8'hFF, b=8'h01, cin=0, start pulsed at edge k. Required: busy=1 from k+1; done=1 only in the cycle after edge k+8; sum=8'h00, cout=1, overflow=0.
- Signed overflow: a=8'h7F, b=8'h01, cin=0. Required: sum=8'h80, cout=0, overflow=1. Then a=8'h80, b=8'h80. Required: sum=8'h00, cout=1, overflow=1.
- Carry-in path and result hold: a=0, b=0, cin=1. Required: sum=8'h01, cout=0. Outputs hold 8'h01 while idle for 20 cycles with random a and b.
- Busy-time changes: start pulsed again and a/b changed during RUN. Required: no restart, original result delivered, exactly one done pulse.
- Reset mid-operation: rst=1 at the 4th RUN cycle. Required: next cycle busy=0, done=0, sum=0, cout=0, overflow=0, and no done pulse later. A following start with a=8'h12, b=8'h34 gives sum=8'h46.
- Throughput and random check: start tied high for 1000 random operands at WIDTH=8 and WIDTH=16. Required: one done per WIDTH+2 cycles; every {cout,sum} equals a+b+cin; overflow matches the signed rule.
